intersection_sequencer: RTL and testbench

INTERSECTION_SEQUENCER -- requirements
Module: intersection_sequencer

---
 rtl/intersection_sequencer.sv | 110 +++++++++++
 tb/tb_intersection_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/intersection_sequencer.sv
// intersection_sequencer: two-road traffic light controller with pedestrian walk, demand-driven secondary phase and fault flash
// Ports: clk, reset (sync, active-high); fault, secondaryRoadSensor, pedRequest in;
//        primaryRoadLight_RYG / secondaryRoadLight_RYG ([2]=R,[1]=Y,[0]=G), walk, phase (state code), secServed (S_GREEN entry pulse) out.
module intersection_sequencer #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int MIN_GREEN = 10,
  parameter int SEC_GREEN = 6,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fault,
  input  logic       secondaryRoadSensor,
  input  logic       pedRequest,
  output logic [2:0] primaryRoadLight_RYG,
  output logic [2:0] secondaryRoadLight_RYG,
  output logic       walk,
  output logic [2:0] phase,
  output logic       secServed
);
  typedef enum logic [2:0] {
    P_GREEN  = 3'd0,
    P_YELLOW = 3'd1,
    ALLRED1  = 3'd2,
    S_GREEN  = 3'd3,
    S_YELLOW = 3'd4,
    ALLRED2  = 3'd5,
    FAULT    = 3'd6
  } state_t;
  localparam int M1   = MIN_GREEN > SEC_GREEN ? MIN_GREEN : SEC_GREEN;
  localparam int M2   = YELLOW_T > ALLRED_T ? YELLOW_T : ALLRED_T;
  localparam int CMAX = M1 > M2 ? M1 : M2;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = $clog2(TICK_DIV);
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sec_req_q, sec_req_d, ped_req_q, ped_req_d;
  logic          walk_en_q, walk_en_d, flash_q, flash_d;
  logic [2:0]    pri_q, pri_d, sec_q, sec_d;
  logic          walk_q, walk_d, served_q, served_d;
  logic          tick, entry, s_entry;
  always_comb begin
    tick = presc_q == PW'(TICK_DIV - 1);
    state_d = state_q;
    if (fault) state_d = FAULT;
    else begin
      unique case (state_q)
        P_GREEN:  if (tick && cnt_q >= CW'(MIN_GREEN - 1) && (sec_req_q || ped_req_q)) state_d = P_YELLOW;
        P_YELLOW: if (tick && cnt_q == CW'(YELLOW_T - 1)) state_d = ALLRED1;
        ALLRED1:  if (tick && cnt_q == CW'(ALLRED_T - 1)) state_d = S_GREEN;
        S_GREEN:  if (tick && cnt_q == CW'(SEC_GREEN - 1)) state_d = S_YELLOW;
        S_YELLOW: if (tick && cnt_q == CW'(YELLOW_T - 1)) state_d = ALLRED2;
        ALLRED2:  if (tick && cnt_q == CW'(ALLRED_T - 1)) state_d = P_GREEN;
        FAULT:    state_d = ALLRED2;
        default:  state_d = P_GREEN;
      endcase
    end
    entry = state_d != state_q;
    s_entry = entry && state_d == S_GREEN;
    // the prescaler free-runs across state changes, so a state's first tick may be partial
    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d = entry ? '0 : (tick && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    // requests are consumed when the secondary phase starts; anything arriving later re-arms them
    sec_req_d = s_entry ? 1'b0 : sec_req_q | secondaryRoadSensor;
    ped_req_d = s_entry ? 1'b0 : ped_req_q | pedRequest;
    walk_en_d = s_entry ? ped_req_q : walk_en_q;
    flash_d = (entry && state_d == FAULT) ? 1'b1 : (tick && state_q == FAULT) ? ~flash_q : flash_q;
    // outputs decode the next state so the registered lamps line up with state_q
    pri_d = state_d == P_GREEN ? 3'b001 : state_d == P_YELLOW ? 3'b010 :
            state_d == FAULT ? {1'b0, flash_d, 1'b0} : 3'b100;
    sec_d = state_d == S_GREEN ? 3'b001 : state_d == S_YELLOW ? 3'b010 :
            state_d == FAULT ? {1'b0, flash_d, 1'b0} : 3'b100;
    walk_d = state_d == S_GREEN && walk_en_d;
    served_d = s_entry;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= P_GREEN;
      presc_q   <= '0;
      cnt_q     <= '0;
      sec_req_q <= 1'b0;
      ped_req_q <= 1'b0;
      walk_en_q <= 1'b0;
      flash_q   <= 1'b0;
      pri_q     <= 3'b001;
      sec_q     <= 3'b100;
      walk_q    <= 1'b0;
      served_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      sec_req_q <= sec_req_d;
      ped_req_q <= ped_req_d;
      walk_en_q <= walk_en_d;
      flash_q   <= flash_d;
      pri_q     <= pri_d;
      sec_q     <= sec_d;
      walk_q    <= walk_d;
      served_q  <= served_d;
    end
  end
  assign primaryRoadLight_RYG   = pri_q;
  assign secondaryRoadLight_RYG = sec_q;
  assign walk                   = walk_q;
  assign phase                  = state_q;
  assign secServed              = served_q;
endmodule

// File: tb/tb_intersection_sequencer.sv
// tb_intersection_sequencer: directed self-checking bench for intersection_sequencer
module tb_intersection_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fault = 1'b0;
  logic       secondaryRoadSensor = 1'b0;
  logic       pedRequest = 1'b0;
  logic [2:0] primaryRoadLight_RYG, secondaryRoadLight_RYG, phase;
  logic       walk, secServed;
  int checks = 0;
  int errors = 0;
  intersection_sequencer #(
    .TICK_DIV(4), .MIN_GREEN(5), .SEC_GREEN(4), .YELLOW_T(2), .ALLRED_T(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fault(fault),
    .secondaryRoadSensor(secondaryRoadSensor),
    .pedRequest(pedRequest),
    .primaryRoadLight_RYG(primaryRoadLight_RYG),
    .secondaryRoadLight_RYG(secondaryRoadLight_RYG),
    .walk(walk),
    .phase(phase),
    .secServed(secServed)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // Stays in phase p from its first cycle until it changes (or max_len cycles pass),
  // checking lamps every cycle and pulsing inputs at chosen cycle offsets.
  task automatic measure(input string tag, input logic [2:0] p, input int exp_len, input int max_len,
                         input logic [2:0] ep, input logic [2:0] es, input logic ew,
                         input int sec_at, input int ped_at, input int fault_at);
    int n = 0;
    int sp = 0;
    logic bad = 1'b0;
    chk({tag, "/phase"}, phase, p);
    while (phase === p && n < max_len) begin
      if (primaryRoadLight_RYG !== ep || secondaryRoadLight_RYG !== es || walk !== ew) bad = 1'b1;
      sp += int'(secServed);
      secondaryRoadSensor = n == sec_at;
      pedRequest = n == ped_at;
      if (n == fault_at) fault = 1'b1;
      n++;
      cyc();
    end
    secondaryRoadSensor = 1'b0;
    pedRequest = 1'b0;
    chk({tag, "/len"}, n, exp_len);
    chk({tag, "/lamps"}, bad, 0);
    chk({tag, "/served"}, sp, p == 3'd3 ? 1 : 0);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "/pri"}, primaryRoadLight_RYG, 3'b001);
    chk({tag, "/sec"}, secondaryRoadLight_RYG, 3'b100);
    chk({tag, "/phase"}, phase, 3'd0);
    chk({tag, "/walk"}, walk, 1'b0);
    chk({tag, "/served"}, secServed, 1'b0);
  endtask
  initial begin
    logic y;
    cyc(); cyc(); cyc();
    chk_reset_outputs("rst0");
    reset = 1'b0;
    measure("idle", 3'd0, 100, 100, 3'b001, 3'b100, 1'b0, -1, -1, -1);
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    measure("s.pg", 3'd0, 20, 200, 3'b001, 3'b100, 1'b0, 2, -1, -1);
    measure("s.py", 3'd1, 8, 200, 3'b010, 3'b100, 1'b0, -1, -1, -1);
    measure("s.ar1", 3'd2, 4, 200, 3'b100, 3'b100, 1'b0, -1, -1, -1);
    measure("s.sg", 3'd3, 16, 200, 3'b100, 3'b001, 1'b0, -1, 5, -1);
    measure("s.sy", 3'd4, 8, 200, 3'b100, 3'b010, 1'b0, -1, -1, -1);
    measure("s.ar2", 3'd5, 4, 200, 3'b100, 3'b100, 1'b0, -1, -1, -1);
    measure("late.pg", 3'd0, 20, 200, 3'b001, 3'b100, 1'b0, -1, -1, -1);
    measure("late.py", 3'd1, 8, 200, 3'b010, 3'b100, 1'b0, -1, -1, -1);
    measure("late.ar1", 3'd2, 4, 200, 3'b100, 3'b100, 1'b0, -1, -1, -1);
    measure("late.sg", 3'd3, 16, 200, 3'b100, 3'b001, 1'b1, -1, -1, -1);
    measure("late.sy", 3'd4, 8, 200, 3'b100, 3'b010, 1'b0, -1, -1, -1);
    measure("late.ar2", 3'd5, 4, 200, 3'b100, 3'b100, 1'b0, -1, -1, -1);
    measure("p.pg", 3'd0, 20, 200, 3'b001, 3'b100, 1'b0, -1, 2, -1);
    measure("p.py", 3'd1, 8, 200, 3'b010, 3'b100, 1'b0, -1, -1, -1);
    measure("p.ar1", 3'd2, 4, 200, 3'b100, 3'b100, 1'b0, -1, -1, -1);
    measure("p.sg", 3'd3, 7, 200, 3'b100, 3'b001, 1'b1, -1, -1, 6);
    for (int k = 0; k < 10; k++) begin
      y = k == 0 ? 1'b1 : ((k - 1) / 4) % 2 == 1;
      chk($sformatf("flt%0d/phase", k), phase, 3'd6);
      chk($sformatf("flt%0d/lamps", k), {primaryRoadLight_RYG, secondaryRoadLight_RYG},
          {1'b0, y, 1'b0, 1'b0, y, 1'b0});
      chk($sformatf("flt%0d/walk", k), {walk, secServed}, 2'b00);
      if (k == 9) fault = 1'b0;
      cyc();
    end
    measure("f.ar2", 3'd5, 3, 200, 3'b100, 3'b100, 1'b0, -1, -1, -1);
    measure("r.pg", 3'd0, 20, 200, 3'b001, 3'b100, 1'b0, 2, -1, -1);
    measure("r.py", 3'd1, 8, 200, 3'b010, 3'b100, 1'b0, -1, -1, -1);
    measure("r.ar1", 3'd2, 4, 200, 3'b100, 3'b100, 1'b0, -1, -1, -1);
    measure("r.sg", 3'd3, 16, 200, 3'b100, 3'b001, 1'b0, 5, 3, -1);
    chk("r.sy/phase", phase, 3'd4);
    cyc(); cyc(); cyc();
    chk("r.sy/still", phase, 3'd4);
    reset = 1'b1;
    cyc();
    chk_reset_outputs("rst1");
    reset = 1'b0;
    measure("r.cleared", 3'd0, 40, 40, 3'b001, 3'b100, 1'b0, -1, -1, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
